// File: rtl/fp_align_pkg.sv
// Shared definitions for the floating-point alignment shifter: operand widths
// and a behavioural reference for the shift-and-sticky operation.
package fp_align_pkg;

   localparam int GRS_BITS = 2;

   function automatic int ext_width(input int width);
      return width + GRS_BITS;
   endfunction

   // Reference alignment on a zero-extended operand of up to 64 bits.
   // Returns {sticky, shifted[63:0]}.
   function automatic logic [64:0] align_ref(input logic [63:0] ext,
                                             input int unsigned shift);
      logic [63:0] mask;
      logic        sticky;
      if (shift >= 64) begin
         return {|ext, 64'd0};
      end
      mask   = (64'd1 << shift) - 64'd1;
      sticky = |(ext & mask);
      return {sticky, ext >> shift};
   endfunction

endpackage

// File: rtl/fp_align_stage.sv
// One registered slice of the alignment shifter: right-shifts its operand,
// folds the dropped bits into sticky, and carries a sideband alongside.
module fp_align_stage
   import fp_align_pkg::*;
#(
   parameter int DATA_W  = 10,
   parameter int SHAMT_W = 5,
   parameter int SIDE_W  = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_sticky,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [SIDE_W-1:0]  in_side,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_sticky,
   output logic [SIDE_W-1:0]  out_side
);

   logic [DATA_W-1:0] shifted;
   logic              dropped;
   int                shamt_i;

   // A shift amount at or beyond DATA_W drops every bit; >> zero-fills.
   always_comb begin
      shifted = in_data >> in_shamt;
      dropped = 1'b0;
      shamt_i = int'(in_shamt);
      for (int i = 0; i < DATA_W; i++) begin
         if (i < shamt_i) begin
            dropped = dropped | in_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid <= in_valid;
      end
   end

   // Payload only moves with a real beat; the valid bit qualifies it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data   <= '0;
         out_sticky <= 1'b0;
         out_side   <= '0;
      end else if (load && in_valid) begin
         out_data   <= shifted;
         out_sticky <= in_sticky | dropped;
         out_side   <= in_side;
      end
   end

endmodule

// File: rtl/fp_align_shifter.sv
// Two-stage elastic alignment shifter: coarse shift by a multiple of four,
// then fine shift by the residual 0..3, producing guard/round and sticky.
module fp_align_shifter
   import fp_align_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SHIFT_WIDTH = 5,
   parameter int TAG_WIDTH   = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_value,
   input  logic [SHIFT_WIDTH-1:0] in_shift,
   input  logic [TAG_WIDTH-1:0]   in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH+1:0]       out_aligned,
   output logic                   out_sticky,
   output logic [TAG_WIDTH-1:0]   out_tag
);

   localparam int EXT_W  = ext_width(WIDTH);
   localparam int SIDE_1 = GRS_BITS + TAG_WIDTH;

   typedef struct packed {
      logic [EXT_W-1:0]    data;
      logic                sticky;
      logic [GRS_BITS-1:0] residual_shift;
      logic [TAG_WIDTH-1:0] tag;
   } payload_t;

   payload_t                 s1_q;
   payload_t                 s2_q;
   logic                     s1_valid;
   logic                     s2_valid;
   logic                     s1_load;
   logic                     s2_load;
   logic [EXT_W-1:0]         ext;
   logic [SHIFT_WIDTH-1:0]   coarse_shamt;
   logic [SIDE_1-1:0]        s1_side_in;
   logic [SIDE_1-1:0]        s1_side_q;

   // Ready depends only on downstream state and out_ready, never on in_valid.
   assign s2_load  = !s2_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   assign ext          = {in_value, {GRS_BITS{1'b0}}};
   assign coarse_shamt = {in_shift[SHIFT_WIDTH-1:GRS_BITS], {GRS_BITS{1'b0}}};
   assign s1_side_in   = {in_shift[GRS_BITS-1:0], in_tag};

   fp_align_stage #(
      .DATA_W  (EXT_W),
      .SHAMT_W (SHIFT_WIDTH),
      .SIDE_W  (SIDE_1)
   ) u_coarse (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (s1_load),
      .in_valid   (in_valid),
      .in_data    (ext),
      .in_sticky  (1'b0),
      .in_shamt   (coarse_shamt),
      .in_side    (s1_side_in),
      .out_valid  (s1_valid),
      .out_data   (s1_q.data),
      .out_sticky (s1_q.sticky),
      .out_side   (s1_side_q)
   );

   assign s1_q.residual_shift = s1_side_q[SIDE_1-1:TAG_WIDTH];
   assign s1_q.tag            = s1_side_q[TAG_WIDTH-1:0];

   fp_align_stage #(
      .DATA_W  (EXT_W),
      .SHAMT_W (GRS_BITS),
      .SIDE_W  (TAG_WIDTH)
   ) u_fine (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (s2_load),
      .in_valid   (s1_valid),
      .in_data    (s1_q.data),
      .in_sticky  (s1_q.sticky),
      .in_shamt   (s1_q.residual_shift),
      .in_side    (s1_q.tag),
      .out_valid  (s2_valid),
      .out_data   (s2_q.data),
      .out_sticky (s2_q.sticky),
      .out_side   (s2_q.tag)
   );

   assign s2_q.residual_shift = '0;

   assign out_valid   = s2_valid;
   assign out_aligned = s2_q.data;
   assign out_sticky  = s2_q.sticky;
   assign out_tag     = s2_q.tag;

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter: directed vectors, streaming,
// back-pressure, random handshakes and asynchronous reset.
module tb_fp_align_shifter;
   import fp_align_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_value;
   logic [4:0] in_shift;
   logic [8:0] in_tag;
   logic       out_valid;
   logic       out_ready;
   logic [9:0] out_aligned;
   logic       out_sticky;
   logic [8:0] out_tag;

   typedef struct {
      logic [9:0] aligned;
      logic       sticky;
      logic [8:0] tag;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   total = 0;
   int   bad   = 0;

   fp_align_shifter #(.WIDTH(8), .SHIFT_WIDTH(5), .TAG_WIDTH(9)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_value    (in_value),
      .in_shift    (in_shift),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_aligned (out_aligned),
      .out_sticky  (out_sticky),
      .out_tag     (out_tag)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] v, input logic [4:0] s,
                                  input logic [8:0] t);
      logic [64:0] r;
      exp_t        m;
      r         = align_ref({54'd0, v, 2'b00}, int'(s));
      m.aligned = r[9:0];
      m.sticky  = r[64];
      m.tag     = t;
      return m;
   endfunction

   task automatic new_beat();
      in_value = 8'($urandom);
      in_shift = 5'($urandom);
      in_tag   = 9'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_value = '0; in_shift = '0; in_tag = '0;
      #1;
      total++;
      if ({out_valid, out_aligned, out_sticky, out_tag} !== 21'd0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state: valid=%b aligned=%h sticky=%b tag=%h in_ready=%b, need 0/0/0/0/1",
                  out_valid, out_aligned, out_sticky, out_tag, in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] tv_v[9] = '{8'h81, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h01, 8'h01};
      logic [4:0] tv_s[9] = '{5'd3, 5'd0, 5'd10, 5'd31, 5'd31, 5'd5, 5'd9, 5'd2, 5'd3};
      logic [9:0] tv_a[9] = '{10'b0001000000, 10'b1111111100, 10'd0, 10'd0, 10'd0,
                             10'd0, 10'd1, 10'd1, 10'd0};
      logic       tv_k[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1;
         in_value = tv_v[i]; in_shift = tv_s[i];
         in_tag   = (i == 0) ? 9'h1A5 : 9'(i * 37);
         #1;
         total++;
         if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL vec%0d_in_ready: got %b need 1", i, in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL vec%0d_early: out_valid=%b after one edge, need 0", i, out_valid);
         end
         @(negedge clk); #1;
         total++;
         if (out_valid !== 1'b1 || out_aligned !== tv_a[i] || out_sticky !== tv_k[i] ||
             out_tag !== ((i == 0) ? 9'h1A5 : 9'(i * 37))) begin
            bad++;
            $display("FAIL vec%0d: valid=%b aligned=%b sticky=%b tag=%h, need 1 %b %b %h",
                     i, out_valid, out_aligned, out_sticky, out_tag, tv_a[i], tv_k[i],
                     (i == 0) ? 9'h1A5 : 9'(i * 37));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int got = 0;
      int rdy_drop = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid  = (k < 16);
         in_value  = 8'($urandom_range(1, 255));
         in_shift  = 5'(k);
         in_tag    = 9'(k + 100);
         #1;
         if (in_valid && in_ready !== 1'b1) rdy_drop++;
         if (k >= 2 && k < 18) begin
            total++;
            if (out_valid !== 1'b1) begin
               bad++;
               $display("FAIL b2b_gap: cycle %0d out_valid=%b need 1", k, out_valid);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL b2b_extra: unexpected beat aligned=%h", out_aligned);
            end else begin
               e = sb.pop_front();
               got++;
               if (out_aligned !== e.aligned || out_sticky !== e.sticky || out_tag !== e.tag) begin
                  bad++;
                  $display("FAIL b2b_data: got %h/%b/%h need %h/%b/%h",
                           out_aligned, out_sticky, out_tag, e.aligned, e.sticky, e.tag);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(model(in_value, in_shift, in_tag));
      end
      in_valid = 1'b0;
      total++;
      if (got != 16 || rdy_drop != 0) begin
         bad++;
         $display("FAIL b2b_count: outputs=%0d ready_drops=%0d, need 16 0", got, rdy_drop);
      end
   endtask

   task automatic test_stall();
      int         acc = 0;
      int         got = 0;
      logic [9:0] h_a;
      logic       h_s;
      logic [8:0] h_t;
      logic       held = 1'b0;
      @(negedge clk);
      new_beat();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         out_ready = 1'b0; in_valid = 1'b1;
         #1;
         if (out_valid && held) begin
            total++;
            if (out_aligned !== h_a || out_sticky !== h_s || out_tag !== h_t) begin
               bad++;
               $display("FAIL stall_hold: got %h/%b/%h held %h/%b/%h",
                        out_aligned, out_sticky, out_tag, h_a, h_s, h_t);
            end
         end
         if (out_valid && !held) begin
            h_a = out_aligned; h_s = out_sticky; h_t = out_tag; held = 1'b1;
         end
         if (in_ready) begin
            sb.push_back(model(in_value, in_shift, in_tag));
            acc++;
            @(posedge clk); #1;
            new_beat();
         end
      end
      total++;
      if (acc != 2 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL stall_accept: accepted=%0d in_ready=%b, need 2 0", acc, in_ready);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1;
         #1;
         if (out_valid) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL stall_dup: extra beat aligned=%h", out_aligned);
            end else begin
               e = sb.pop_front();
               got++;
               if (out_aligned !== e.aligned || out_sticky !== e.sticky || out_tag !== e.tag) begin
                  bad++;
                  $display("FAIL stall_drain: got %h/%b/%h need %h/%b/%h",
                           out_aligned, out_sticky, out_tag, e.aligned, e.sticky, e.tag);
               end
            end
         end
      end
      total++;
      if (got != 2 || sb.size() != 0) begin
         bad++;
         $display("FAIL stall_count: drained=%0d left=%0d, need 2 0", got, sb.size());
      end
   endtask

   task automatic test_random();
      int         sent = 0;
      int         cyc  = 0;
      logic       prev_stall = 1'b0;
      logic [9:0] p_a;
      logic       p_s;
      logic [8:0] p_t;
      new_beat();
      while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (prev_stall) begin
            total++;
            if (out_valid !== 1'b1 || out_aligned !== p_a || out_sticky !== p_s || out_tag !== p_t) begin
               bad++;
               $display("FAIL rand_hold: got %b %h/%b/%h held %h/%b/%h",
                        out_valid, out_aligned, out_sticky, out_tag, p_a, p_s, p_t);
            end
         end
         prev_stall = out_valid && !out_ready;
         p_a = out_aligned; p_s = out_sticky; p_t = out_tag;
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rand_extra: unexpected beat aligned=%h", out_aligned);
            end else begin
               e = sb.pop_front();
               if (out_aligned !== e.aligned || out_sticky !== e.sticky || out_tag !== e.tag) begin
                  bad++;
                  $display("FAIL rand_data: got %h/%b/%h need %h/%b/%h",
                           out_aligned, out_sticky, out_tag, e.aligned, e.sticky, e.tag);
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(in_value, in_shift, in_tag));
            sent++;
            @(posedge clk); #1;
            new_beat();
         end
         cyc++;
      end
      in_valid = 1'b0;
      total++;
      if (sent != 10000 || sb.size() != 0) begin
         bad++;
         $display("FAIL rand_budget: sent=%0d pending=%0d after %0d cycles", sent, sb.size(), cyc);
      end
   endtask

   task automatic test_async_reset();
      int stale = 0;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; new_beat();
      repeat (2) begin
         @(negedge clk);
         new_beat();
      end
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL areset_fill: out_valid=%b in_ready=%b, need 1 0", out_valid, in_ready);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, out_aligned, out_sticky, out_tag} !== 21'd0) begin
         bad++;
         $display("FAIL areset_clear: valid=%b aligned=%h sticky=%b tag=%h, need all 0",
                  out_valid, out_aligned, out_sticky, out_tag);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL areset_ready: in_ready=%b need 1", in_ready);
      end
      out_ready = 1'b1;
      repeat (5) begin
         @(negedge clk); #1;
         if (out_valid !== 1'b0) stale++;
      end
      total++;
      if (stale != 0) begin
         bad++;
         $display("FAIL areset_stale: %0d cycles with out_valid=1, need 0", stale);
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_stall();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
